// File: rtl/text_scan_pkg.sv
// Shared definitions for the text-mode scanout path: geometry defaults,
// fetch FSM state encoding and the address-width helper.
package text_scan_pkg;

  // XGA text geometry defaults.
  localparam int unsigned DEF_WIDTH      = 128;
  localparam int unsigned DEF_HEIGHT     = 48;
  localparam int unsigned DEF_CHAR_WIDTH = 8;
  localparam int unsigned DEF_GLYPH_W    = 8;
  localparam int unsigned DEF_GLYPH_H    = 16;

  // Fetch FSM states (2-bit encoding, also visible on the debug port).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_CHAR = 2'd1,
    ST_RD_FONT = 2'd2,
    ST_CAPTURE = 2'd3
  } fetch_state_t;

  // Bits needed to address n entries; never less than 1 so a
  // single-entry dimension still gets a legal port width.
  function automatic int log2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/text_scan_glyph_shifter.sv
// Two-deep glyph pipeline: a next-slot buffer feeding a glyph_w-bit
// MSB-first shift register that drives the 1-bit pixel stream.
//
// Handshake: pix_valid/pix_out/pix_eol/pix_eof are registered; once
// pix_valid is high they stay stable until the cycle pix_ready is also
// high (the accept). Only flush may drop pix_valid without an accept,
// and flush wins over a simultaneous accept.
module glyph_shifter
  import text_scan_pkg::*;
#(
  parameter int unsigned GLYPH_W = DEF_GLYPH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               load,
  input  logic [GLYPH_W-1:0] load_bits,
  input  logic               load_eol,
  input  logic               load_eof,
  output logic               slot_free,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_out,
  output logic               pix_eol,
  output logic               pix_eof
);

  localparam int CW = log2w(GLYPH_W);
  localparam logic [CW-1:0] C_LAST = CW'(GLYPH_W - 1);

  logic [GLYPH_W-1:0] slot_q, slot_d, sh_q, sh_d;
  logic               slot_eol_q, slot_eol_d, slot_eof_q, slot_eof_d;
  logic               sh_eol_q, sh_eol_d, sh_eof_q, sh_eof_d;
  logic               next_full_q, next_full_d;
  logic               valid_q, valid_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               accept, take, direct;

  assign accept = valid_q && pix_ready;
  // Shifter can take a new glyph when empty or its last bit leaves now.
  assign take   = !valid_q || (accept && (cnt_q == C_LAST));
  // Fresh glyph bypasses the slot only when the slot has nothing older.
  assign direct = take && !next_full_q && load;

  // Next-state for slot, shifter and bit counter.
  always_comb begin
    slot_d      = slot_q;
    slot_eol_d  = slot_eol_q;
    slot_eof_d  = slot_eof_q;
    sh_d        = sh_q;
    sh_eol_d    = sh_eol_q;
    sh_eof_d    = sh_eof_q;
    next_full_d = next_full_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    if (accept) begin
      sh_d  = sh_q << 1;
      cnt_d = cnt_q + 1'b1;
    end
    if (take) begin
      cnt_d = '0;
      if (next_full_q) begin
        sh_d        = slot_q;
        sh_eol_d    = slot_eol_q;
        sh_eof_d    = slot_eof_q;
        valid_d     = 1'b1;
        next_full_d = 1'b0;
      end else if (load) begin
        sh_d     = load_bits;
        sh_eol_d = load_eol;
        sh_eof_d = load_eof;
        valid_d  = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
    if (load && !direct) begin
      slot_d      = load_bits;
      slot_eol_d  = load_eol;
      slot_eof_d  = load_eof;
      next_full_d = 1'b1;
    end
    if (flush) begin
      slot_d      = '0;
      slot_eol_d  = 1'b0;
      slot_eof_d  = 1'b0;
      sh_d        = '0;
      sh_eol_d    = 1'b0;
      sh_eof_d    = 1'b0;
      next_full_d = 1'b0;
      valid_d     = 1'b0;
      cnt_d       = '0;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      slot_eol_q  <= 1'b0;
      slot_eof_q  <= 1'b0;
      sh_q        <= '0;
      sh_eol_q    <= 1'b0;
      sh_eof_q    <= 1'b0;
      next_full_q <= 1'b0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      slot_q      <= slot_d;
      slot_eol_q  <= slot_eol_d;
      slot_eof_q  <= slot_eof_d;
      sh_q        <= sh_d;
      sh_eol_q    <= sh_eol_d;
      sh_eof_q    <= sh_eof_d;
      next_full_q <= next_full_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign slot_free = !next_full_d;
  assign pix_valid = valid_q;
  assign pix_out   = valid_q && sh_q[GLYPH_W-1];
  assign pix_eol   = valid_q && (cnt_q == C_LAST) && sh_eol_q;
  assign pix_eof   = valid_q && (cnt_q == C_LAST) && sh_eof_q;

endmodule

// File: rtl/text_scan.sv
// Text-mode scanout: walks the character buffer in display order, looks
// up each glyph row in the font ROM and streams it out one pixel at a time.
module text_scan
  import text_scan_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned HEIGHT     = DEF_HEIGHT,
  parameter int unsigned CHAR_WIDTH = DEF_CHAR_WIDTH,
  parameter int unsigned GLYPH_W    = DEF_GLYPH_W,
  parameter int unsigned GLYPH_H    = DEF_GLYPH_H
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        rd_en,
  output logic [log2w(WIDTH)-1:0]     rd_x,
  output logic [log2w(HEIGHT)-1:0]    rd_y,
  input  logic [CHAR_WIDTH-1:0]       rd_char,
  output logic                        font_en,
  output logic [CHAR_WIDTH-1:0]       font_char,
  output logic [log2w(GLYPH_H)-1:0]   font_row,
  input  logic [GLYPH_W-1:0]          font_bits,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic                        pix_out,
  output logic                        pix_eol,
  output logic                        pix_eof,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);

  localparam int XW = log2w(WIDTH);
  localparam int YW = log2w(HEIGHT);
  localparam int RW = log2w(GLYPH_H);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [RW-1:0] R_LAST = RW'(GLYPH_H - 1);

  fetch_state_t          state_q, state_d;
  logic                  captured_q, captured_d;
  logic [XW-1:0]         col_q, col_d;
  logic [YW-1:0]         row_q, row_d;
  logic [RW-1:0]         frow_q, frow_d;
  logic [CHAR_WIDTH-1:0] font_char_q, font_char_d;
  logic                  busy_q, busy_d;
  logic                  load, slot_free, cell_eol, cell_eof;

  assign cell_eol = (col_q == X_LAST);
  assign cell_eof = cell_eol && (row_q == Y_LAST) && (frow_q == R_LAST);

  // Fetch FSM: strobes, counter advance and next state. start overrides
  // everything and restarts the walk at cell (0,0), scanline 0.
  always_comb begin
    state_d     = state_q;
    captured_d  = captured_q;
    col_d       = col_q;
    row_d       = row_q;
    frow_d      = frow_q;
    font_char_d = font_char_q;
    rd_en       = 1'b0;
    font_en     = 1'b0;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_RD_CHAR: begin
        rd_en   = 1'b1;
        state_d = ST_RD_FONT;
      end
      ST_RD_FONT: begin
        font_en     = 1'b1;
        font_char_d = rd_char;
        state_d     = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!captured_q) begin
          // First CAPTURE cycle: font_bits is valid now, hand it over.
          load = 1'b1;
          if (cell_eol) begin
            col_d = '0;
            if (frow_q == R_LAST) begin
              frow_d = '0;
              row_d  = (row_q == Y_LAST) ? '0 : row_q + 1'b1;
            end else begin
              frow_d = frow_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
          if (cell_eof)       state_d = ST_IDLE;
          else if (slot_free) state_d = ST_RD_CHAR;
          else                captured_d = 1'b1;
        end else if (slot_free) begin
          // Waiting for the next-slot to drain before the next fetch.
          captured_d = 1'b0;
          state_d    = ST_RD_CHAR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d    = ST_RD_CHAR;
      captured_d = 1'b0;
      col_d      = '0;
      row_d      = '0;
      frow_d     = '0;
    end
  end

  // busy: set by start, cleared once the end-of-frame pixel is taken.
  always_comb begin
    busy_d = busy_q;
    if (start)                                     busy_d = 1'b1;
    else if (pix_valid && pix_ready && pix_eof)    busy_d = 1'b0;
  end

  // FSM state, fetch counters and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      captured_q  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      frow_q      <= '0;
      font_char_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      captured_q  <= captured_d;
      col_q       <= col_d;
      row_q       <= row_d;
      frow_q      <= frow_d;
      font_char_q <= font_char_d;
      busy_q      <= busy_d;
    end
  end

  // The ROM index must be valid alongside font_en, which is the same
  // cycle rd_char arrives, so pass it through then and hold it after.
  assign font_char = (state_q == ST_RD_FONT) ? rd_char : font_char_q;
  assign rd_x      = col_q;
  assign rd_y      = row_q;
  assign font_row  = frow_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

  glyph_shifter #(
    .GLYPH_W (GLYPH_W)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (start),
    .load      (load),
    .load_bits (font_bits),
    .load_eol  (cell_eol),
    .load_eof  (cell_eof),
    .slot_free (slot_free),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_out   (pix_out),
    .pix_eol   (pix_eol),
    .pix_eof   (pix_eof)
  );

endmodule

// File: tb/tb_text_scan.sv
// Bench for text_scan on a small 3x3 text screen with 3-scanline glyphs.
module tb_text_scan;

  localparam int W  = 3;
  localparam int H  = 3;
  localparam int GH = 3;
  localparam int GW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          rd_en;
  logic [1:0]    rd_x, rd_y;
  logic [CW-1:0] rd_char = '0;
  logic          font_en;
  logic [CW-1:0] font_char;
  logic [1:0]    font_row;
  logic [GW-1:0] font_bits = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic          pix_out, pix_eol, pix_eof;
  logic          busy;
  logic [1:0]    dbg_state;

  text_scan #(
    .WIDTH(W), .HEIGHT(H), .CHAR_WIDTH(CW), .GLYPH_W(GW), .GLYPH_H(GH)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_char(rd_char),
    .font_en(font_en), .font_char(font_char), .font_row(font_row),
    .font_bits(font_bits),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_out(pix_out),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memories: screen buffer and font ROM ----------------
  logic [CW-1:0] scr_mem [H][W];

  function automatic logic [GW-1:0] font_fn(input logic [CW-1:0] c, input int row);
    return c + 8'(row * 91);
  endfunction

  always @(posedge clk) begin
    if (rd_en)   rd_char   <= scr_mem[rd_y][rd_x];
    if (font_en) font_bits <= font_fn(font_char, int'(font_row));
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];   // {glyph_last, eof, eol, pixel}
  bit   active = 0, seen_first = 0, gap_mode = 0, rand_mode = 0, stall_prev = 0;
  logic [2:0] held;
  int   started, finished, eol_cnt, pix_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected frame straight from the scan-order rules.
  task automatic build_frame();
    logic [GW-1:0] g;
    exp_q.delete();
    for (int l = 0; l < H * GH; l++)
      for (int x = 0; x < W; x++) begin
        g = font_fn(scr_mem[l / GH][x], l % GH);
        for (int b = GW - 1; b >= 0; b--)
          exp_q.push_back({b == 0, (b == 0) && (x == W - 1) && (l == H * GH - 1),
                           (b == 0) && (x == W - 1), g[b]});
      end
  endtask

  // One clock cycle: check the current cycle's outputs against the model,
  // update the model for what the coming edge does, then advance.
  task automatic step();
    logic [3:0] e;
    bit eof_acc;
    eof_acc = 0;
    if (reset) begin
      if (stall_prev) begin
        check("stall_valid", pix_valid, 1);
        check("stall_data", {pix_out, pix_eol, pix_eof}, held);
      end
      check("busy", busy, active);
      if (!active) check("idle_strobes", {pix_valid, rd_en, font_en}, 0);
      if (gap_mode && active && seen_first) check("no_gap", pix_valid, 1);
      if (rd_en) begin
        check("rd_slot_free", (started - finished) <= 1, 1);
        started++;
      end
      if (pix_valid) seen_first = 1;
      if (pix_valid && pix_ready && !start) begin
        if (exp_q.size() == 0) check("extra_pixel", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("pixel", {pix_eof, pix_eol, pix_out}, e[2:0]);
          if (e[3]) finished++;
          if (e[2]) eof_acc = 1;
        end
        if (pix_eol) eol_cnt++;
        pix_cnt++;
      end
      stall_prev = pix_valid && !pix_ready && !start;
      held = {pix_out, pix_eol, pix_eof};
      if (start) begin
        build_frame();
        active = 1; seen_first = 0; started = 0; finished = 0;
        eol_cnt = 0; pix_cnt = 0;
      end else if (eof_acc) begin
        active = 0;
      end
    end
    @(negedge clk);
    pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic fill_screen();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) scr_mem[y][x] = 8'($urandom_range(0, 255));
  endtask

  // start pulse plus the fixed k+1 / k+2 / k+4 timing checks.
  task automatic start_and_check();
    start = 1'b1;
    step();
    start = 1'b0;
    check("k1_rd_en", rd_en, 1);
    check("k1_rd_xy", {rd_x, rd_y}, 0);
    check("k1_valid", pix_valid, 0);
    check("k1_busy", busy, 1);
    step();
    check("k2_font_en", font_en, 1);
    check("k2_font_char", font_char, scr_mem[0][0]);
    check("k2_font_row", font_row, 0);
    step();
    check("k3_valid", pix_valid, 0);
    step();
    check("k4_valid", pix_valid, 1);
  endtask

  task automatic run_frame(input int budget);
    int cyc;
    cyc = 0;
    while (active && cyc < budget) begin
      step();
      cyc++;
    end
    check("frame_done", active, 0);
    check("queue_empty", exp_q.size(), 0);
    check("eol_count", eol_cnt, H * GH);
    check("pix_count", pix_cnt, W * H * GH * GW);
    step();  // busy must be low the cycle after the eof accept
  endtask

  // ---------------- main sequence ----------------
  initial begin
    fill_screen();
    repeat (3) @(negedge clk);
    check("rst_outputs", {rd_en, font_en, pix_valid, pix_out, pix_eol, pix_eof, busy}, 0);
    check("rst_addr", {rd_x, rd_y, font_row, font_char}, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    repeat (3) step();

    // Frame 1: always ready, stream must be gap-free after first pixel.
    gap_mode = 1;
    start_and_check();
    run_frame(2000);
    gap_mode = 0;

    // Frame 2: random back-pressure, new screen content.
    fill_screen();
    rand_mode = 1;
    start_and_check();
    run_frame(4000);

    // Frame 3: abort after five pixels, then a full re-scan.
    fill_screen();
    start_and_check();
    begin
      int cyc;
      cyc = 0;
      while (pix_cnt < 5 && cyc < 500) begin step(); cyc++; end
      check("abort_reach_px5", pix_cnt, 5);
    end
    start_and_check();
    run_frame(4000);

    // Frame 4: asynchronous reset in the middle of a glyph.
    rand_mode = 0;
    fill_screen();
    start_and_check();
    repeat (20) step();
    #2 reset = 1'b0;
    #1;
    check("async_rst_out", {rd_en, font_en, pix_valid, pix_out, pix_eol, pix_eof, busy}, 0);
    check("async_rst_addr", {rd_x, rd_y, font_row, font_char}, 0);
    check("async_rst_state", dbg_state, 0);
    exp_q.delete();
    active = 0; stall_prev = 0; seen_first = 0;
    repeat (3) step();
    reset = 1'b1;
    repeat (15) step();   // idle_strobes checks: nothing until start

    // Frame 5: recovery after reset, random back-pressure.
    rand_mode = 1;
    start_and_check();
    run_frame(4000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
